// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, NOP word,
// default reset PC and the word-alignment helper used for redirect targets.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_HOLD    = 2'd2,
      ST_DISCARD = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Single-outstanding-request instruction fetch unit. Holds one fetched word
// for the IF/ID latch and restarts fetch on redirects, discarding stale data.
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        pc_write_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] address_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_add4_o,
   output logic        valid_o,
   output logic        flush_o
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  target;
   logic [31:0]  pc_next;

   assign target  = align_word(redirect_pc_i);
   assign pc_next = pc + 32'd4;

   // NOTE: every register here uses non-blocking assignment so all state
   // updates see the values from before the clock edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         imem_req_o  <= 1'b0;
         imem_addr_o <= 32'h0;
         address_o   <= 32'h0;
         instr_o     <= NOP_INSTR;
         pc_add4_o   <= 32'h0;
         valid_o     <= 1'b0;
         flush_o     <= 1'b0;
      end else begin
         imem_req_o <= 1'b0;
         flush_o    <= redirect_i;
         case (state)
            ST_IDLE: begin
               imem_req_o <= 1'b1;
               state      <= ST_WAIT;
               if (redirect_i) begin
                  pc          <= target;
                  imem_addr_o <= target;
               end else begin
                  imem_addr_o <= pc;
               end
            end
            ST_WAIT: begin
               if (redirect_i) begin
                  pc <= target;
                  // Response already here: drop it and refetch at once.
                  if (imem_rvalid_i) begin
                     imem_req_o  <= 1'b1;
                     imem_addr_o <= target;
                  end else begin
                     state <= ST_DISCARD;
                  end
               end else if (imem_rvalid_i) begin
                  instr_o   <= imem_rdata_i;
                  valid_o   <= 1'b1;
                  address_o <= pc;
                  pc_add4_o <= pc_next;
                  state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (redirect_i || pc_write_i) begin
                  valid_o    <= 1'b0;
                  instr_o    <= NOP_INSTR;
                  imem_req_o <= 1'b1;
                  state      <= ST_WAIT;
                  if (redirect_i) begin
                     pc          <= target;
                     imem_addr_o <= target;
                  end else begin
                     pc          <= pc_next;
                     imem_addr_o <= pc_next;
                  end
               end
            end
            ST_DISCARD: begin
               if (redirect_i) pc <= target;
               // Stale response retires the old request; fetch the newest PC.
               if (imem_rvalid_i) begin
                  imem_req_o  <= 1'b1;
                  imem_addr_o <= redirect_i ? target : pc;
                  state       <= ST_WAIT;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus queues expected requests and
// fetched words; a negedge monitor pops and compares as the DUT presents them.
module tb_if_fetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_write = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = 32'hBAD0_BAD0;
   logic [31:0] address;
   logic [31:0] instr;
   logic [31:0] pc_add4;
   logic        valid;
   logic        flush;

   if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .pc_write_i    (pc_write),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_rvalid_i (rvalid),
      .imem_rdata_i  (rdata),
      .address_o     (address),
      .instr_o       (instr),
      .pc_add4_o     (pc_add4),
      .valid_o       (valid),
      .flush_o       (flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
      logic [31:0] add4;
   } fetch_t;

   logic [31:0] exp_req[$];
   fetch_t      exp_fetch[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          flush_seen = 0;
   int          exp_flush = 0;
   int          lat = 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: event not expected or never seen", name);
   endtask

   task automatic push_fetch(input logic [31:0] a, input logic [31:0] a4);
      fetch_t f;
      f.addr = a;
      f.word = mem_word(a);
      f.add4 = a4;
      exp_fetch.push_back(f);
   endtask

   task automatic wait_valid();
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (valid) return;
      end
      fail_now("valid_timeout");
   endtask

   task automatic check_reset_outputs();
      check("rst_req", {31'b0, imem_req}, 32'h0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_valid", {31'b0, valid}, 32'h0);
      check("rst_flush", {31'b0, flush}, 32'h0);
      check("rst_instr", instr, NOP_INSTR);
      check("rst_address", address, 32'h0);
      check("rst_pc_add4", pc_add4, 32'h0);
   endtask

   // Memory model: answers each request after lat cycles, one beat of rvalid.
   initial begin : mem_model
      bit          pending = 1'b0;
      int          cnt = 0;
      logic [31:0] a = 32'h0;
      forever begin
         @(negedge clk);
         rvalid = 1'b0;
         rdata  = 32'hBAD0_BAD0;
         if (pending) begin
            if (cnt == 0) begin
               rvalid  = 1'b1;
               rdata   = mem_word(a);
               pending = 1'b0;
            end else begin
               cnt--;
            end
         end
         if (imem_req) begin
            check("one_outstanding", {31'b0, pending}, 32'h0);
            pending = 1'b1;
            a       = imem_addr;
            cnt     = lat - 1;
         end
      end
   end

   initial begin : monitor
      logic   prev_valid = 1'b0;
      logic [31:0] e;
      fetch_t f;
      forever begin
         @(negedge clk);
         if (flush) flush_seen++;
         if (imem_req) begin
            if (exp_req.size() == 0) fail_now("unexpected_req");
            else begin
               e = exp_req.pop_front();
               check("req_addr", imem_addr, e);
            end
         end
         if (valid && !prev_valid) begin
            if (exp_fetch.size() == 0) fail_now("unexpected_valid");
            else begin
               f = exp_fetch.pop_front();
               check("fetch_address", address, f.addr);
               check("fetch_instr", instr, f.word);
               check("fetch_pc_add4", pc_add4, f.add4);
            end
         end
         if (!valid) check("nop_when_invalid", instr, NOP_INSTR);
         prev_valid = valid;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [31:0] s_addr, s_instr, s_add4;

      // Reset state, then straight-line fetch with 1-cycle memory.
      repeat (2) @(negedge clk);
      check_reset_outputs();
      lat = 1;
      exp_req.push_back(32'h0);  push_fetch(32'h0, 32'h4);
      exp_req.push_back(32'h4);  push_fetch(32'h4, 32'h8);
      exp_req.push_back(32'h8);  push_fetch(32'h8, 32'hC);
      pc_write = 1'b1;
      rst = 1'b0;
      wait_valid();
      wait_valid();
      wait_valid();
      pc_write = 1'b0;

      // Advance to 0x10, stall five cycles, then release to 0x14.
      exp_req.push_back(32'hC);  push_fetch(32'hC, 32'h10);
      exp_req.push_back(32'h10); push_fetch(32'h10, 32'h14);
      pc_write = 1'b1;
      wait_valid();
      wait_valid();
      pc_write = 1'b0;
      s_addr = address; s_instr = instr; s_add4 = pc_add4;
      repeat (5) begin
         @(negedge clk);
         check("stall_valid", {31'b0, valid}, 32'h1);
         check("stall_address", address, s_addr);
         check("stall_instr", instr, s_instr);
         check("stall_pc_add4", pc_add4, s_add4);
      end
      exp_req.push_back(32'h14); push_fetch(32'h14, 32'h18);
      pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
      wait_valid();

      // Redirect to 0x103 while waiting on a 3-cycle memory.
      lat = 3;
      exp_req.push_back(32'h18);
      pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h103;
      exp_flush++;
      exp_req.push_back(32'h100); push_fetch(32'h100, 32'h104);
      @(negedge clk);
      redirect = 1'b0;
      wait_valid();
      check("flush_count_discard", flush_seen, exp_flush);

      // Redirect in the same cycle as the response arrives.
      lat = 1;
      exp_req.push_back(32'h104);
      pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
      @(negedge clk);
      redirect = 1'b1;
      redirect_pc = 32'h200;
      exp_flush++;
      exp_req.push_back(32'h200); push_fetch(32'h200, 32'h204);
      @(negedge clk);
      redirect = 1'b0;
      wait_valid();

      // Redirect beats pc_write in HOLD.
      pc_write = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h300;
      exp_flush++;
      exp_req.push_back(32'h300); push_fetch(32'h300, 32'h304);
      @(negedge clk);
      pc_write = 1'b0;
      redirect = 1'b0;
      wait_valid();
      check("flush_count_priority", flush_seen, exp_flush);

      // Unaligned redirect to the top word, then wrap to zero.
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      exp_flush++;
      exp_req.push_back(32'hFFFF_FFFC); push_fetch(32'hFFFF_FFFC, 32'h0);
      @(negedge clk);
      redirect = 1'b0;
      wait_valid();
      exp_req.push_back(32'h0); push_fetch(32'h0, 32'h4);
      pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
      wait_valid();

      // Reset during WAIT; the late response lands while still in reset.
      lat = 3;
      exp_req.push_back(32'h4);
      pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
      #2 rst = 1'b1;
      #1 check_reset_outputs();
      repeat (5) @(negedge clk);
      check_reset_outputs();
      exp_req.push_back(32'h0); push_fetch(32'h0, 32'h4);
      rst = 1'b0;
      wait_valid();

      repeat (3) @(negedge clk);
      check("flush_count_final", flush_seen, exp_flush);
      check("req_queue_drained", exp_req.size(), 32'h0);
      check("fetch_queue_drained", exp_fetch.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have one parameter, RESET_PC (default 32'h0000_0000), the PC loaded on reset.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 The port list SHALL be as follows.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- pc_write_i  in  1  1 = downstream IF/ID latch consumes the held instruction this cycle; 0 = stall.
- redirect_i  in  1  branch/jump taken; restart fetch.
- redirect_pc_i  in  32  redirect target.
- imem_req_o  out  1  single-cycle fetch request pulse.
- imem_addr_o  out  32  fetch address; valid while imem_req_o=1.
- imem_rvalid_i  in  1  read data valid; at least 1 cycle after request.
- imem_rdata_i  in  32  instruction word.
- address_o  out  32  PC of the held instruction.
- instr_o  out  32  held instruction.
- pc_add4_o  out  32  address_o+4.
- valid_o  out  1  held instruction is valid.
- flush_o  out  1  one-cycle pulse the cycle after redirect_i is accepted.

Function
REQ-004 The block SHALL implement FSM states IDLE, WAIT, HOLD and DISCARD.
REQ-005 At most one memory request SHALL be outstanding at any time.
REQ-006 All outputs SHALL be registered.
REQ-007 IDLE SHALL exit on the first clock after reset release: imem_req_o<=1, imem_addr_o<=pc, go to WAIT.
REQ-008 WAIT with imem_rvalid_i=1 SHALL capture instr<=imem_rdata_i, set valid_o<=1 and go to HOLD. Request-to-valid_o latency is at least 2 cycles.
REQ-009 HOLD SHALL drive address_o=pc, pc_add4_o=pc+4, instr_o=captured word and valid_o=1.
REQ-010 HOLD with pc_write_i=0 SHALL hold all outputs unchanged, for any stall length.
REQ-011 HOLD with pc_write_i=1 SHALL perform pc<=pc+4, valid_o<=0, imem_req_o<=1, imem_addr_o<=pc+4, and go to WAIT.
REQ-012 redirect_i SHALL take priority over pc_write_i. Its target is {redirect_pc_i[31:2],2'b00}, and flush_o<=1 for one cycle.
REQ-013 Redirect in IDLE or HOLD SHALL perform pc<=target, valid_o<=0, issue a request to target, and go to WAIT.
REQ-014 Redirect in WAIT with imem_rvalid_i=0 SHALL perform pc<=target and go to DISCARD without issuing a request.
REQ-015 Redirect in WAIT with imem_rvalid_i=1 in the same cycle SHALL drop the data, issue a request to target, and stay in WAIT.
REQ-016 DISCARD SHALL handle the stale response and further redirects:
- imem_rvalid_i=1: drop the data, issue a request to pc, go to WAIT.
- redirect: update pc, stay in DISCARD.
REQ-017 pc_write_i SHALL be ignored outside HOLD.
REQ-018 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-019 When valid_o=0, instr_o SHALL be 32'h0000_0013 (NOP) and address_o/pc_add4_o SHALL retain their last values.
REQ-020 imem_rvalid_i in IDLE or HOLD SHALL be ignored.

Reset
REQ-021 Asserting rst_i SHALL immediately force pc=RESET_PC, state=IDLE, imem_req_o=0, imem_addr_o=0, valid_o=0, flush_o=0, instr_o=NOP, address_o=0 and pc_add4_o=0.
REQ-022 Reset mid-request SHALL abandon the outstanding request; a late imem_rvalid_i during IDLE is ignored (REQ-020).
REQ-023 Reset release SHALL be synchronised to clk_i by the system; the block relies on a glitch-free deassertion.

Structure
REQ-024 The shared package fetch_pkg SHALL hold the FSM state enum, the NOP constant (32'h0000_0013) and the default RESET_PC.
REQ-025 No sub-module SHALL be required; the PC incrementer is inline logic.

Verification
REQ-026 Reset, 1-cycle memory, pc_write_i=1 constant -> imem_addr_o sequence 0,4,8; valid_o pulses carry instr_o matching memory and pc_add4_o=address_o+4.
REQ-027 HOLD at PC 0x10 with pc_write_i=0 for 5 cycles -> outputs stable and no imem_req_o; on pc_write_i=1 the next request goes to 0x14.
REQ-028 Redirect to 0x103 in WAIT, memory latency 3 -> flush_o pulses once, the stale word is never shown, the next request goes to 0x100, and valid_o then shows address_o=0x100.
REQ-029 Redirect coincident with imem_rvalid_i, and redirect with pc_write_i=1 in HOLD -> the redirect wins and the data/advance is dropped.
REQ-030 PC 0xFFFFFFFC consumed -> next request to 0x00000000.
REQ-031 rst_i asserted mid-WAIT with a late imem_rvalid_i -> outputs at reset values and the first request after release goes to RESET_PC.
